mealy_seq_sched: RTL
====================

Name: mealy_seq_sched

Overview:
- Scheduler and configurator for a shared Mealy serial pattern detector.
- NCH serial bit streams compete for one detector engine through a valid/ready arbiter, one bit per cycle.
- Per-channel match history is held locally, so each stream is detected independently, as if it had its own detector.
- Pattern, length and overlap mode are programmable; reset default is pattern 11011, overlapping.

Parameters:
NCH, 4, number of serial input channels (2..8)
PLEN_MAX, 8, maximum pattern length in bits
CNT_W, 8, width of the saturating match counter

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
cfg_wr  input  1  config write strobe, single cycle
cfg_pattern  input  PLEN_MAX  pattern; bit [len-1] is the oldest bit, bit [0] the newest
cfg_len  input  $clog2(PLEN_MAX)+1  pattern length, legal 1..PLEN_MAX
cfg_overlap  input  1  1 = overlapping detection, 0 = non-overlapping
cfg_busy  output  1  high during the FLUSH cycle
cfg_err  output  1  one-cycle pulse when a cfg_wr is rejected
bit_valid  input  NCH  per-channel bit available
bit_in  input  NCH  per-channel serial bit
bit_ready  output  NCH  one-hot grant; a bit is consumed when valid & ready
det_valid  output  1  one-cycle pulse: pattern completed
det_ch  output  $clog2(NCH)  channel that completed the pattern
match_cnt  output  CNT_W  total matches, saturating

Behaviour:
- Reset (sync, rst=1):
  - pattern=11011, len=5, overlap=1.
  - All histories and fill counts cleared; rr pointer=0.
  - State RUN.
  - cfg_busy=0, cfg_err=0, det_valid=0, det_ch=0, match_cnt=0, bit_ready=0 while rst is high.
- FSM, two states:
  - RUN: arbitrate and detect.
  - FLUSH: one cycle; clear all histories and fill counts; bit_ready=0; cfg_busy=1; then return to RUN.
- Config write:
  - cfg_wr with legal cfg_len in RUN:
    - Latch pattern, len and overlap; clear match_cnt.
    - Go to FLUSH.
    - bit_ready is forced 0 in the cfg_wr cycle, so no bit is consumed or lost.
  - cfg_len=0 or cfg_len>PLEN_MAX: config unchanged, cfg_err pulses the next cycle, state unchanged.
  - cfg_wr during FLUSH: ignored (no error).
- Arbitration, RUN only:
  - Round-robin starting at the rr pointer; grant the first channel with bit_valid=1.
  - bit_ready is combinational from bit_valid and the rr pointer.
  - Only one bit is ever asserted.
  - After a grant, rr pointer = granted index + 1, wrapping at NCH.
  - No valid input: no grant, pointer holds.
- Per-channel state:
  - hist[PLEN_MAX-1:0]: shift register, newest bit at [0].
  - fill: bits received since clear, saturating at PLEN_MAX.
- On grant to channel i with bit b:
  - nh = {hist_i, b}; match = (fill_i+1 >= len) && (nh[len-1:0] == pattern[len-1:0]).
  - If match and overlap=0: hist_i=0, fill_i=0.
  - Otherwise: hist_i=nh, fill_i=min(fill_i+1, PLEN_MAX).
- Detection output:
  - match in grant cycle T → det_valid=1 and det_ch=i in cycle T+1, registered, latency 1.
  - match_cnt increments in the same T+1 edge and saturates at 2^CNT_W-1.
- Channels without a grant keep their state unchanged.
- Back-to-back grants to the same channel are legal; at most one det per cycle.

Optional Feature:
- Macro SEQ_SCHED_FIXED_PRIO_EN.
- Defined: fixed priority arbitration; lowest index with bit_valid wins; rr pointer removed.
- Undefined: round-robin as above.
- All other behaviour is identical.

Test Plan:
- Reset defaults, ch0 only, stream 1,1,0,1,1,0,1,1 → det_valid pulses after bits 5 and 8, det_ch=0, match_cnt=2.
- cfg_wr pattern=11011, len=5, overlap=0; same ch0 stream → exactly one det (after bit 5), match_cnt=1, cfg_busy high one cycle after the write.
- ch0 and ch1 both continuously valid, each sending 1,1,0,1,1 → grants alternate 0,1,0,… (ch0 first after reset); det for ch0 then ch1 on consecutive cycles; match_cnt=2; the interleaved bits never mix.
- ch0 sends 1,1,0,1; cfg_wr (same pattern) arrives while ch0 is valid → no grant that cycle; FLUSH clears history; next bit 1 → no det; match_cnt=0.
- cfg_wr with cfg_len=0, then cfg_len=9 → cfg_err pulses each time; default 11011 detection still works.
- CNT_W=2, feed 1,1,0,1,1 repeated (overlap) → match_cnt saturates at 3; assert rst mid-stream → all outputs 0 the next cycle and detection restarts from empty history.

Source files
------------

// File: rtl/mealy_seq_sched.sv
// Shared Mealy serial pattern detector: arbitrates NCH bit streams into one engine with per-channel history.
// Optional macro SEQ_SCHED_FIXED_PRIO_EN selects fixed-priority arbitration instead of round-robin.
module mealy_seq_sched #(
  parameter int NCH      = 4,
  parameter int PLEN_MAX = 8,
  parameter int CNT_W    = 8,
  localparam int LEN_W   = $clog2(PLEN_MAX) + 1,
  localparam int CH_W    = $clog2(NCH)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cfg_wr,
  input  logic [PLEN_MAX-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]    cfg_len,
  input  logic                cfg_overlap,
  output logic                cfg_busy,
  output logic                cfg_err,
  input  logic [NCH-1:0]      bit_valid,
  input  logic [NCH-1:0]      bit_in,
  output logic [NCH-1:0]      bit_ready,
  output logic                det_valid,
  output logic [CH_W-1:0]     det_ch,
  output logic [CNT_W-1:0]    match_cnt
);

  typedef enum logic {RUN, FLUSH} state_t;

  state_t              state_reg, state_next;
  logic [PLEN_MAX-1:0] pattern_reg;
  logic [LEN_W-1:0]    len_reg;
  logic                overlap_reg;
  logic                cfg_err_reg;
  logic                det_valid_reg;
  logic [CH_W-1:0]     det_ch_reg;
  logic [CNT_W-1:0]    match_cnt_reg;

  logic [PLEN_MAX-1:0] hist_all [NCH];
  logic [LEN_W-1:0]    fill_all [NCH];
  logic [CH_W-1:0]     scan_idx [NCH];

  logic                cfg_legal, cfg_accept, cfg_reject, arb_en;
  logic                gnt_any, fire, match;
  logic [CH_W-1:0]     gnt_idx;
  logic [PLEN_MAX-1:0] nh, len_mask;
  logic [LEN_W-1:0]    fill_sel, fill_inc;

  assign cfg_legal  = (cfg_len != '0) && (cfg_len <= LEN_W'(PLEN_MAX));
  assign cfg_accept = cfg_wr && cfg_legal && (state_reg == RUN);
  assign cfg_reject = cfg_wr && !cfg_legal && (state_reg == RUN);
  // Accepted config writes stall the arbiter so the pending bit survives the flush.
  assign arb_en     = !rst && (state_reg == RUN) && !cfg_accept;

`ifdef SEQ_SCHED_FIXED_PRIO_EN
  for (genvar gi = 0; gi < NCH; gi++) begin : g_scan
    assign scan_idx[gi] = CH_W'(gi);
  end
`else
  logic [CH_W-1:0] rr_reg;

  for (genvar gi = 0; gi < NCH; gi++) begin : g_scan
    assign scan_idx[gi] = CH_W'((int'(rr_reg) + gi) % NCH);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_reg <= '0;
    end else if (fire) begin
      rr_reg <= (gnt_idx == CH_W'(NCH - 1)) ? '0 : gnt_idx + 1'b1;
    end
  end
`endif

  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    for (int k = 0; k < NCH; k++) begin
      if (!gnt_any && bit_valid[scan_idx[k]]) begin
        gnt_any = 1'b1;
        gnt_idx = scan_idx[k];
      end
    end
  end

  assign fire      = arb_en && gnt_any;
  assign bit_ready = fire ? (NCH'(1) << gnt_idx) : '0;

  // Match is evaluated only for the granted channel, against its own history.
  assign nh       = {hist_all[gnt_idx][PLEN_MAX-2:0], bit_in[gnt_idx]};
  assign fill_sel = fill_all[gnt_idx];
  assign fill_inc = (fill_sel == LEN_W'(PLEN_MAX)) ? fill_sel : fill_sel + 1'b1;
  assign len_mask = {PLEN_MAX{1'b1}} >> (LEN_W'(PLEN_MAX) - len_reg);
  assign match    = fire
                 && (({1'b0, fill_sel} + (LEN_W + 1)'(1)) >= {1'b0, len_reg})
                 && (((nh ^ pattern_reg) & len_mask) == '0);

  for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
    logic [PLEN_MAX-1:0] hist_reg;
    logic [LEN_W-1:0]    fill_reg;

    always_ff @(posedge clk) begin
      if (rst || state_reg == FLUSH) begin
        hist_reg <= '0;
        fill_reg <= '0;
      end else if (fire && gnt_idx == CH_W'(gi)) begin
        if (match && !overlap_reg) begin
          hist_reg <= '0;
          fill_reg <= '0;
        end else begin
          hist_reg <= nh;
          fill_reg <= fill_inc;
        end
      end
    end

    assign hist_all[gi] = hist_reg;
    assign fill_all[gi] = fill_reg;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      RUN:     if (cfg_accept) state_next = FLUSH;
      FLUSH:   state_next = RUN;
      default: state_next = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= RUN;
      pattern_reg   <= PLEN_MAX'(5'b11011);
      len_reg       <= LEN_W'(5);
      overlap_reg   <= 1'b1;
      cfg_err_reg   <= 1'b0;
      det_valid_reg <= 1'b0;
      det_ch_reg    <= '0;
      match_cnt_reg <= '0;
    end else begin
      state_reg     <= state_next;
      cfg_err_reg   <= cfg_reject;
      det_valid_reg <= match;
      if (match) det_ch_reg <= gnt_idx;
      if (cfg_accept) begin
        pattern_reg   <= cfg_pattern;
        len_reg       <= cfg_len;
        overlap_reg   <= cfg_overlap;
        match_cnt_reg <= '0;
      end else if (match && match_cnt_reg != {CNT_W{1'b1}}) begin
        match_cnt_reg <= match_cnt_reg + 1'b1;
      end
    end
  end

  assign cfg_busy  = !rst && (state_reg == FLUSH);
  assign cfg_err   = cfg_err_reg;
  assign det_valid = det_valid_reg;
  assign det_ch    = det_ch_reg;
  assign match_cnt = match_cnt_reg;

endmodule
